// File: rtl/rv32i_types.sv
// Shared RV32 type definitions: M-extension operation encodings and the
// iterative multiply/divide control states.
package rv32i_types;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, sharing one counter and FSM.
module muldiv_unit
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  muldiv_funct3_t  funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0]  ONE_X   = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  MIN_X   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

  muldiv_state_t    state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_inc_s;
  muldiv_funct3_t   op_r;
  logic             neg_r;
  logic [XLEN-1:0]  opb_r;
  logic [2*XLEN-1:0] acc_r, acc_step_s, acc_neg_s;
  logic [XLEN-1:0]  result_r, final_s, fast_val_s;

  logic             s1_signed_s, s2_signed_s, s1_neg_s, s2_neg_s, neg_in_s;
  logic [XLEN-1:0]  mag1_s, mag2_s;
  logic             div_zero_s, div_ovf_s, fast_hit_s;
  logic [XLEN:0]    mul_sum_s, div_shl_s, div_diff_s;
  logic [XLEN-1:0]  quo_s, rem_s;

  // Operand signedness and magnitudes for the incoming request
  always_comb begin
    s1_signed_s = 1'b0;
    s2_signed_s = 1'b0;
    case (funct3)
      F3_MULH:       begin s1_signed_s = 1'b1; s2_signed_s = 1'b1; end
      F3_MULHSU:     begin s1_signed_s = 1'b1; s2_signed_s = 1'b0; end
      F3_DIV, F3_REM: begin s1_signed_s = 1'b1; s2_signed_s = 1'b1; end
      default:       begin s1_signed_s = 1'b0; s2_signed_s = 1'b0; end
    endcase
    s1_neg_s = s1_signed_s & rs1_data[XLEN-1];
    s2_neg_s = s2_signed_s & rs2_data[XLEN-1];
    mag1_s   = s1_neg_s ? ((~rs1_data) + ONE_X) : rs1_data;
    mag2_s   = s2_neg_s ? ((~rs2_data) + ONE_X) : rs2_data;
    // Remainder follows the dividend sign; everything else is sign XOR
    if (funct3 == F3_REM || funct3 == F3_REMU) begin
      neg_in_s = s1_neg_s;
    end else begin
      neg_in_s = s1_neg_s ^ s2_neg_s;
    end
  end

  // Divide corner cases that complete without iterating
  always_comb begin
    div_zero_s = funct3[2] && (rs2_data == '0);
    div_ovf_s  = (funct3 == F3_DIV || funct3 == F3_REM) &&
                 (rs1_data == MIN_X) && (rs2_data == '1);
    fast_hit_s = div_zero_s || div_ovf_s;
    if (div_zero_s) begin
      fast_val_s = funct3[1] ? rs1_data : '1;
    end else begin
      fast_val_s = funct3[1] ? '0 : rs1_data;
    end
  end

  // One iteration of the shared datapath plus the completed result
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : '0);
    div_shl_s  = acc_r[2*XLEN-1:XLEN-1];
    div_diff_s = div_shl_s - {1'b0, opb_r};
    if (!op_r[2]) begin
      acc_step_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end else if (!div_diff_s[XLEN]) begin
      acc_step_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
    end else begin
      acc_step_s = {div_shl_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
    end
    acc_neg_s = neg_r ? ((~acc_step_s) + ONE_2X) : acc_step_s;
    quo_s     = neg_r ? ((~acc_step_s[XLEN-1:0]) + ONE_X) : acc_step_s[XLEN-1:0];
    rem_s     = neg_r ? ((~acc_step_s[2*XLEN-1:XLEN]) + ONE_X) : acc_step_s[2*XLEN-1:XLEN];
    case (op_r)
      F3_MUL:                         final_s = acc_neg_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   final_s = acc_neg_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                final_s = quo_s;
      default:                        final_s = rem_s;
    endcase
  end

  assign cnt_inc_s = cnt_r + ONE_C;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = fast_hit_s ? DONE : CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_inc_s == CNT_W'(XLEN)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      CALC:    begin busy = 1'b1; done = 1'b0; end
      DONE:    begin busy = 1'b0; done = 1'b1; end
      default: begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= '0;
      op_r     <= F3_MUL;
      neg_r    <= 1'b0;
      opb_r    <= '0;
      acc_r    <= '0;
      result_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r  <= funct3;
            neg_r <= neg_in_s;
            cnt_r <= '0;
            // Multiply: mcand in opb, multiplier in low half; divide: divisor in opb, dividend low
            opb_r <= funct3[2] ? mag2_s : mag1_s;
            acc_r <= {{XLEN{1'b0}}, (funct3[2] ? mag1_s : mag2_s)};
            if (fast_hit_s) begin
              result_r <= fast_val_s;
            end
          end
        end
        CALC: begin
          acc_r <= acc_step_s;
          cnt_r <= cnt_inc_s;
          if (state_next_s == DONE) begin
            result_r <= final_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues expected result and
// latency per accepted operation; a negedge monitor checks every done pulse.
`timescale 1ns/1ns
module tb_muldiv_unit;
  import rv32i_types::*;

  logic           clk, rst, start;
  muldiv_funct3_t funct3;
  logic [31:0]    rs1_data, rs2_data;
  logic           busy, done;
  logic [31:0]    result;

  typedef struct {
    logic [31:0] res;
    int          lat;
    time         t_acc;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic        stab_en = 1'b0;
  logic        have_last = 1'b0;
  logic [31:0] last_res = 32'h0;
  int          done_seen = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency is the cycle number after acceptance: the accepting edge opens cycle 1
  always @(negedge clk) begin : monitor
    exp_t e;
    int   lat;
    if (done) begin
      done_seen++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done result=%h", result);
      end else begin
        e = q.pop_front();
        lat = int'(($time - e.t_acc + 5) / 10);
        if (result !== e.res || lat != e.lat) begin
          failures++;
          $display("FAIL %s result=%h lat=%0d expected result=%h lat=%0d",
                   e.name, result, lat, e.res, e.lat);
        end
      end
      have_last = 1'b1;
      last_res  = result;
    end else if (stab_en && have_last) begin
      checks++;
      if (result !== last_res) begin
        failures++;
        $display("FAIL result_stable result=%h expected %h", result, last_res);
      end
    end
  end

  task automatic wait_empty(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout pending=%0d expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic issue(input muldiv_funct3_t f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input int lat, input string name);
    exp_t e;
    @(negedge clk);
    funct3 = f; rs1_data = a; rs2_data = b; start = 1'b1;
    @(posedge clk);
    e.res = exp_res; e.lat = lat; e.t_acc = $time; e.name = name;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== (lat > 1)) begin
      failures++;
      $display("FAIL %s_busy busy=%b expected %b", name, busy, (lat > 1));
    end
    wait_empty(100, name);
  endtask

  task automatic check_bit(input logic act, input logic exp, input string name);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected %b", name, act, exp);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    exp_t e;
    time  t0;
    rst = 1'b1; start = 1'b0; funct3 = F3_MUL;
    rs1_data = 32'h0; rs2_data = 32'h0;
    repeat (2) @(negedge clk);
    check_bit(busy, 1'b0, "reset_busy");
    check_bit(done, 1'b0, "reset_done");
    checks++;
    if (result !== 32'h0) begin
      failures++;
      $display("FAIL reset_result got=%h expected 00000000", result);
    end
    rst = 1'b0;

    issue(F3_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7x-3");
    stab_en = 1'b1;
    issue(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_ff");
    issue(F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, "mulh_ff");
    issue(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu_ff");
    issue(F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min");
    issue(F3_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 33, "mul_shift");
    issue(F3_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, "div_-7/2");
    issue(F3_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, "rem_-7%2");
    issue(F3_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div_7/-2");
    issue(F3_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33, "rem_7%-2");
    issue(F3_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 33, "divu_100/7");
    issue(F3_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 33, "remu_100%7");
    issue(F3_DIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 33, "divu_max/1");
    issue(F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, "divu_min/max");
    issue(F3_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1,  "divu_5/0");
    issue(F3_DIV,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 1,  "div_-5/0");
    issue(F3_REMU,   32'h00000009, 32'h00000000, 32'h00000009, 1,  "remu_9%0");
    issue(F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf");
    issue(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");

    // Reset ten cycles into a divide abandons it
    stab_en = 1'b0;
    @(negedge clk);
    funct3 = F3_DIV; rs1_data = 32'hFFFFFF9C; rs2_data = 32'h00000003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_bit(busy, 1'b0, "midop_reset_busy");
    check_bit(done, 1'b0, "midop_reset_done");
    checks++;
    if (result !== 32'h0) begin
      failures++;
      $display("FAIL midop_reset_result got=%h expected 00000000", result);
    end
    done_seen = 0;
    repeat (40) @(negedge clk);
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL midop_no_done pulses=%0d expected 0", done_seen);
    end

    issue(F3_MUL, 32'h00000009, 32'h00000009, 32'h00000051, 33, "mul_post_reset");
    stab_en = 1'b1;

    // start held high: accepts land every 34 cycles
    @(negedge clk);
    funct3 = F3_MUL; rs1_data = 32'h00000003; rs2_data = 32'h00000005; start = 1'b1;
    @(posedge clk);
    t0 = $time;
    for (int k = 0; k < 3; k++) begin
      e.res = 32'h0000000F; e.lat = 33; e.t_acc = t0 + k * 340; e.name = "hold_start";
      q.push_back(e);
    end
    wait_empty(150, "hold_start");
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
